// File: rtl/twitchcore_pkg.sv
// Shared definitions for the twitchcore console UART transmitter:
// register offsets, STATUS bit positions and the serialiser state type.
package twitchcore_pkg;

    localparam logic [3:0] UART_TXDATA = 4'h0;
    localparam logic [3:0] UART_STATUS = 4'h4;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_ACTIVE  = 3;
    localparam int ST_COUNT   = 8;
    localparam int ST_COUNT_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/twitchcore_fifo.sv
// Small synchronous FIFO with head-of-queue read data.
// Ports: clk, reset (async, high), push/wdata, pop/rdata, full, empty, count.
module twitchcore_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rdata   = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/twitchcore_uart_tx.sv
// Memory-mapped 8N1 console transmitter: TXDATA pushes bytes into a FIFO,
// STATUS reports level/busy. Ports: clk, reset, bus_* handshake, tx, busy.
module twitchcore_uart_tx
    import twitchcore_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_valid,
    input  logic        bus_we,
    input  logic [3:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_ready,
    output logic        tx,
    output logic        busy
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    uart_state_t   state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_c;

    logic          fifo_pop;
    logic          fifo_push;
    logic [7:0]    fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    logic          req;
    logic          tx_wr;
    logic          accept;
    logic [31:0]   status;
    logic          unused_wdata;

    assign unused_wdata = ^bus_wdata[31:8];

    twitchcore_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (bus_wdata[7:0]),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A held bus_valid is only seen while bus_ready is low, so each
    // request is acknowledged exactly once. A TXDATA write into a full
    // FIFO waits here until the serialiser frees a slot.
    assign req       = bus_valid & ~bus_ready;
    assign tx_wr     = bus_we & (bus_addr == UART_TXDATA);
    assign accept    = req & (~tx_wr | ~fifo_full);
    assign fifo_push = accept & tx_wr;

    assign busy = (state_q != IDLE) | ~fifo_empty;
    assign tx   = tx_c;

    always_comb begin
        status                         = '0;
        status[ST_EMPTY]               = fifo_empty;
        status[ST_FULL]                = fifo_full;
        status[ST_BUSY]                = busy;
        status[ST_ACTIVE]              = (state_q != IDLE);
        status[ST_COUNT +: ST_COUNT_W] = ST_COUNT_W'(fifo_count);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_ready <= 1'b0;
            bus_rdata <= '0;
        end else begin
            bus_ready <= accept;
            if (accept && !bus_we && bus_addr == UART_STATUS) begin
                bus_rdata <= status;
            end else begin
                bus_rdata <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        tx_c     = 1'b1;
        unique case (state_q)
            IDLE: begin
                tx_c = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    baud_d   = '0;
                    bit_d    = '0;
                    state_d  = START;
                end
            end
            START: begin
                tx_c = 1'b0;
                if (baud_q == BAUD_MAX) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                tx_c = shift_q[0];
                if (baud_q == BAUD_MAX) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                tx_c = 1'b1;
                if (baud_q == BAUD_MAX) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/twitchcore_uart_tx.md
Name: twitchcore_uart_tx

Overview:
Memory-mapped console transmitter that consumes the core's store traffic to the peripheral window. Byte writes are buffered in a small FIFO and serialised 8N1, LSB first, on a single tx line. A status register lets firmware poll FIFO level and busy state. It sits directly downstream of the core's load/store port; the decoder in front of it asserts bus_valid only for peripheral addresses.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; must be >= 2.
FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..16.

Ports:
clk  in  1  system clock; all logic on posedge.
reset  in  1  asynchronous, active-high; clears all state.
bus_valid  in  1  core access request; held high until bus_ready.
bus_we  in  1  1 = write, 0 = read.
bus_addr  in  4  byte offset in the peripheral window; 0x0 = TXDATA, 0x4 = STATUS.
bus_wdata  in  32  write data; only [7:0] used.
bus_rdata  out  32  read data; valid in the bus_ready cycle.
bus_ready  out  1  one-cycle acknowledge, registered.
tx  out  1  serial line; idles high.
busy  out  1  high while a frame is on the line or the FIFO is non-empty.

Behaviour:
- Reset (async): tx=1, bus_ready=0, bus_rdata=0, busy=0, FIFO empty (pointers 0, count 0), FSM=IDLE, counters 0.
- Reset mid-frame: tx goes high immediately; the FIFO is flushed and the partial frame is lost.
- Bus handshake:
  - An access is observed when bus_valid=1 and bus_ready=0.
  - bus_ready is registered and pulses for exactly 1 cycle, the cycle after acceptance.
  - bus_ready is never high two cycles in a row, so a held bus_valid is not double-counted.
  - After a pulse, bus_valid is sampled afresh from the next cycle.
- Write to 0x0 with FIFO not full: push bus_wdata[7:0]; bus_ready pulses next cycle. Read-to-ready latency is also 1 cycle.
- Write to 0x0 with FIFO full: stall. bus_ready stays 0 until the serialiser pops; then the push and the ready pulse happen one cycle later. No data is ever dropped.
- Read 0x4 returns, in the ready cycle: [0]=empty, [1]=full, [2]=busy, [3]=FSM!=IDLE, [8 +: 5]=count, other bits 0.
- Read of 0x0, write of 0x4, or any other offset: no side effect; rdata=0 and bus_ready still pulses.
- FIFO:
  - count range 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
  - A push and a pop in the same cycle leave count unchanged.
  - full = (count==FIFO_DEPTH); empty = (count==0).
- Serialiser FSM: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO is not empty, pop the head into an 8-bit shift register, clear baud_cnt, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_cnt=0.
  - DATA: tx=shift[0]. Every CLKS_PER_BIT cycles shift right and increment bit_cnt; after bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then go to IDLE, where the next pop may occur in that same IDLE cycle.
  - Inter-frame gap between back-to-back frames is exactly 1 cycle.
- Timing: frame = 10*CLKS_PER_BIT cycles. The first start bit falls 2 cycles after the accepted write cycle (push edge, then pop/START edge).
- busy = (FSM!=IDLE) | !empty, registered-equivalent from state.
- baud_cnt width is $clog2(CLKS_PER_BIT); bit_cnt is 3 bits; count is $clog2(FIFO_DEPTH)+1 bits.

Decomposition:
- Shared package twitchcore_pkg:
  - register offset constants UART_TXDATA=4'h0, UART_STATUS=4'h4;
  - STATUS bit-index constants;
  - serialiser state enum uart_state_t {IDLE, START, DATA, STOP}.
- One sub-module: twitchcore_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count).
- FSM, baud counter and bus interface stay in the top block.

Test Plan:
- Reset release, no accesses, CLKS_PER_BIT=4 -> tx=1, busy=0, a STATUS read returns 0x00000001 with bus_ready 1 cycle after valid.
- Write 0x41 to 0x0 -> start bit 2 cycles after acceptance; tx bit-times read 0,1,0,0,0,0,0,1,0,1 (4 cycles each); busy falls after the stop bit.
- Write 0x55 then 0xAA back-to-back -> two frames separated by a 1-cycle idle high; bench decoder recovers 0x55, 0xAA.
- Write 9 bytes 0x00..0x08 with FIFO_DEPTH=8 while the line is stalled mid-frame -> the 9th write's bus_ready is delayed until the next pop; all 9 bytes are received in order and none are lost.
- Read offset 0x8, and write to 0x4 -> rdata=0, bus_ready single pulse; FIFO count unchanged.
- Assert reset during DATA of the frame for 0xC3 with 3 bytes queued -> tx=1 immediately; after release, STATUS=0x00000001 and no further frames are sent.
